rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter ENT_NUM, default 4: number of reservation-station entries; power of two, 2..16.
REQ-002 Parameter TAG_W, default 6: width of the ROB tag carried per instruction and on the CDB.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 o_dp_rdy  output  1  at least one free entry; dispatch is accepted this cycle.
REQ-006 i_dp_vld  input  1  dispatch request.
REQ-007 i_dp_op_sel / i_dp_src1_sel / i_dp_src2_sel  input  `ALU_OP_SEL / `ALU_SRC1_SEL / `ALU_SRC2_SEL  ALU controls, stored and forwarded unchanged.
REQ-008 i_dp_rs1, i_dp_rs2  input  `RV32_DATA_WIDTH each  operand value, meaningful when the matching ready bit is 1.
REQ-009 i_dp_rs1_rdy, i_dp_rs2_rdy  input  1 each  operand value present; dispatch sets 1 for unused operands.
REQ-010 i_dp_rs1_tag, i_dp_rs2_tag  input  TAG_W each  producer tag awaited when not ready.
REQ-011 i_dp_pc  input  `RV32_PC_WIDTH; i_dp_imm  input  `RV32_DATA_WIDTH; i_dp_rob_tag  input  TAG_W  destination tag.
REQ-012 i_cdb_vld  input  1; i_cdb_tag  input  TAG_W; i_cdb_data  input  `RV32_DATA_WIDTH  result broadcast.
REQ-013 i_ex_accessable  input  1  ALU execution unit can take an issue this cycle.
REQ-014 o_is_vld  output  1  issue strobe into the ALU execution unit.
REQ-015 o_is_op_sel, o_is_src1_sel, o_is_src2_sel, o_is_rs1, o_is_rs2, o_is_pc, o_is_imm, o_is_rob_tag  outputs  widths as REQ-007..011  selected entry's fields.
REQ-016 i_flush  input  1  squash all entries.

Function
REQ-017 Each entry holds valid, both operand values, both ready bits, both wait tags, and all REQ-007/011 fields.
REQ-018 o_dp_rdy shall be 1 iff at least one entry is invalid at the start of the cycle; an issue in the same cycle does not raise it.
REQ-019 On i_dp_vld && o_dp_rdy && !i_flush, the lowest-index invalid entry is written and becomes valid next edge.
REQ-020 i_dp_vld while o_dp_rdy=0 shall be ignored with no state change.
REQ-021 Wakeup: for every valid entry operand with ready=0 and wait tag == i_cdb_tag while i_cdb_vld=1, value <= i_cdb_data and ready <= 1 at the edge.
REQ-022 Dispatch bypass: a dispatched operand with rdy=0 whose tag matches a same-cycle valid CDB broadcast shall be stored as ready with i_cdb_data.
REQ-023 An entry is ready when valid and both ready bits are 1 at the start of the cycle; wakeup/dispatch readiness takes effect the following cycle (earliest issue = dispatch cycle + 1).
REQ-024 o_is_vld = (any ready entry) && i_ex_accessable && !i_flush; the selected entry is the lowest-index ready entry; o_is_* drive its fields combinationally.
REQ-025 An issued entry shall become invalid at the same edge; a freed entry may be refilled by a dispatch in the following cycle only.
REQ-026 o_is_* outputs when o_is_vld=0 are don't-care but shall not be X after reset.
REQ-027 i_flush=1 shall invalidate every entry at the edge, suppress issue and dispatch that cycle, and override simultaneous wakeup.
REQ-028 Simultaneous dispatch, wakeup and issue in one cycle shall all take effect independently on distinct entries.

Reset
REQ-029 While rst=1 at an edge: all valid and ready bits cleared; next cycle o_dp_rdy=1, o_is_vld=0.
REQ-030 rst asserted mid-operation discards all entries, including a pending issue; payload registers need not be reset.

Structure
REQ-031 ENT_NUM and TAG_W defaults (`RS_ALU_ENT_NUM, `ROB_TAG_WIDTH) live in constants.vh with the existing ALU/RV32 widths.
REQ-032 One sub-module, prio_enc (parameterized lowest-index one-hot select plus valid), is instantiated twice: free-entry allocation and ready-entry selection.

Verification
REQ-033 Dispatch ready op (rs1=5, rs2=7, tag 3), accessable=1 -> o_is_vld one cycle later with o_is_rs1=5, o_is_rs2=7, o_is_rob_tag=3, then empty.
REQ-034 Dispatch rs1 waiting tag 9; CDB tag 9 data 0x1234 two cycles later -> issue the cycle after with o_is_rs1=0x1234; CDB tag 8 causes no wakeup.
REQ-035 Dispatch with rs2 tag 4 in the same cycle as CDB tag 4 data 0xAA -> issue next cycle, o_is_rs2=0xAA.
REQ-036 Fill 4 entries with accessable=0 -> o_dp_rdy=0, 5th dispatch dropped; raise accessable -> issues in order entry 0,1,2,3 on consecutive cycles.
REQ-037 Two ready entries plus i_flush=1 -> o_is_vld=0 that cycle, all entries empty next cycle, o_dp_rdy=1.
REQ-038 rst=1 with 3 valid entries -> next cycle o_is_vld=0, o_dp_rdy=1, no later issue of old entries.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// Shared widths and the per-entry control payload for the ALU reservation station.
package rs_alu_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned PC_W           = 32;
    localparam int unsigned OP_W           = 4;
    localparam int unsigned SRC1_W         = 2;
    localparam int unsigned SRC2_W         = 2;
    localparam int unsigned RS_ALU_ENT_NUM = 4;
    localparam int unsigned ROB_TAG_W      = 6;

    // Fields carried through the station untouched.
    typedef struct packed {
        logic [OP_W-1:0]   op_sel;
        logic [SRC1_W-1:0] src1_sel;
        logic [SRC2_W-1:0] src2_sel;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] imm;
    } ctrl_t;

endpackage

// File: rtl/rs_alu_prio_enc.sv
// Lowest-index one-hot select over a request vector, plus an any-request flag.
module rs_alu_prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        gnt = req & (~req + N'(1));
        any = |req;
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops until both operands arrive, then issues
// the lowest-index ready entry to the ALU.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int unsigned ENT_NUM = RS_ALU_ENT_NUM,
    parameter int unsigned TAG_W   = ROB_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_dp_rdy,
    input  logic              i_dp_vld,
    input  logic [OP_W-1:0]   i_dp_op_sel,
    input  logic [SRC1_W-1:0] i_dp_src1_sel,
    input  logic [SRC2_W-1:0] i_dp_src2_sel,
    input  logic [DATA_W-1:0] i_dp_rs1,
    input  logic [DATA_W-1:0] i_dp_rs2,
    input  logic              i_dp_rs1_rdy,
    input  logic              i_dp_rs2_rdy,
    input  logic [TAG_W-1:0]  i_dp_rs1_tag,
    input  logic [TAG_W-1:0]  i_dp_rs2_tag,
    input  logic [PC_W-1:0]   i_dp_pc,
    input  logic [DATA_W-1:0] i_dp_imm,
    input  logic [TAG_W-1:0]  i_dp_rob_tag,
    input  logic              i_cdb_vld,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic              i_ex_accessable,
    output logic              o_is_vld,
    output logic [OP_W-1:0]   o_is_op_sel,
    output logic [SRC1_W-1:0] o_is_src1_sel,
    output logic [SRC2_W-1:0] o_is_src2_sel,
    output logic [DATA_W-1:0] o_is_rs1,
    output logic [DATA_W-1:0] o_is_rs2,
    output logic [PC_W-1:0]   o_is_pc,
    output logic [DATA_W-1:0] o_is_imm,
    output logic [TAG_W-1:0]  o_is_rob_tag,
    input  logic              i_flush
);

    logic [ENT_NUM-1:0] vld_q, rdy1_q, rdy2_q;
    logic [TAG_W-1:0]   tag1_q [ENT_NUM];
    logic [TAG_W-1:0]   tag2_q [ENT_NUM];
    logic [DATA_W-1:0]  val1_q [ENT_NUM];
    logic [DATA_W-1:0]  val2_q [ENT_NUM];
    logic [TAG_W-1:0]   rob_q  [ENT_NUM];
    ctrl_t              ctrl_q [ENT_NUM];

    logic [ENT_NUM-1:0] free_gnt, is_gnt, ready_vec;
    logic               free_any, ready_any;
    logic               dp_fire, is_fire;
    logic               byp1, byp2;

    rs_alu_prio_enc #(.N(ENT_NUM)) u_alloc_enc (
        .req (~vld_q),
        .gnt (free_gnt),
        .any (free_any)
    );

    rs_alu_prio_enc #(.N(ENT_NUM)) u_issue_enc (
        .req (ready_vec),
        .gnt (is_gnt),
        .any (ready_any)
    );

    // Handshake decode; reset also suppresses issue so a pending entry is never sent.
    always_comb begin
        ready_vec = vld_q & rdy1_q & rdy2_q;
        o_dp_rdy  = free_any;
        dp_fire   = i_dp_vld && free_any && !i_flush;
        is_fire   = ready_any && i_ex_accessable && !i_flush && !rst;
        o_is_vld  = is_fire;
        // Operand produced on the CDB in the same cycle it is dispatched.
        byp1      = !i_dp_rs1_rdy && i_cdb_vld && (i_dp_rs1_tag == i_cdb_tag);
        byp2      = !i_dp_rs2_rdy && i_cdb_vld && (i_dp_rs2_tag == i_cdb_tag);
    end

    // One-hot mux of the selected entry; all-zero when nothing is ready.
    always_comb begin
        o_is_op_sel   = '0;
        o_is_src1_sel = '0;
        o_is_src2_sel = '0;
        o_is_rs1      = '0;
        o_is_rs2      = '0;
        o_is_pc       = '0;
        o_is_imm      = '0;
        o_is_rob_tag  = '0;
        for (int unsigned i = 0; i < ENT_NUM; i++) begin
            if (is_gnt[i]) begin
                o_is_op_sel   = ctrl_q[i].op_sel;
                o_is_src1_sel = ctrl_q[i].src1_sel;
                o_is_src2_sel = ctrl_q[i].src2_sel;
                o_is_rs1      = val1_q[i];
                o_is_rs2      = val2_q[i];
                o_is_pc       = ctrl_q[i].pc;
                o_is_imm      = ctrl_q[i].imm;
                o_is_rob_tag  = rob_q[i];
            end
        end
    end

    // Entry state: reset/flush clear, else wakeup, issue-free and dispatch-write per entry.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            vld_q  <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
        end else begin
            for (int unsigned i = 0; i < ENT_NUM; i++) begin
                if (vld_q[i] && !rdy1_q[i] && i_cdb_vld && (tag1_q[i] == i_cdb_tag)) begin
                    val1_q[i] <= i_cdb_data;
                    rdy1_q[i] <= 1'b1;
                end
                if (vld_q[i] && !rdy2_q[i] && i_cdb_vld && (tag2_q[i] == i_cdb_tag)) begin
                    val2_q[i] <= i_cdb_data;
                    rdy2_q[i] <= 1'b1;
                end
                if (is_fire && is_gnt[i]) begin
                    vld_q[i] <= 1'b0;
                end
                // The allocated entry is invalid, so it never collides with the above.
                if (dp_fire && free_gnt[i]) begin
                    vld_q[i]           <= 1'b1;
                    rdy1_q[i]          <= i_dp_rs1_rdy || byp1;
                    rdy2_q[i]          <= i_dp_rs2_rdy || byp2;
                    val1_q[i]          <= byp1 ? i_cdb_data : i_dp_rs1;
                    val2_q[i]          <= byp2 ? i_cdb_data : i_dp_rs2;
                    tag1_q[i]          <= i_dp_rs1_tag;
                    tag2_q[i]          <= i_dp_rs2_tag;
                    rob_q[i]           <= i_dp_rob_tag;
                    ctrl_q[i].op_sel   <= i_dp_op_sel;
                    ctrl_q[i].src1_sel <= i_dp_src1_sel;
                    ctrl_q[i].src2_sel <= i_dp_src2_sel;
                    ctrl_q[i].pc       <= i_dp_pc;
                    ctrl_q[i].imm      <= i_dp_imm;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Randomised scoreboard bench for rs_alu with a few directed scenarios up front.
module tb_rs_alu;

    localparam int ENT = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [5:0]  rob;
    } iss_t;

    typedef struct {
        bit         vld;
        bit         r1;
        bit         r2;
        logic [5:0] t1;
        logic [5:0] t2;
        iss_t       pay;
    } ent_t;

    logic        clk = 0;
    logic        rst, o_dp_rdy, i_dp_vld;
    logic [3:0]  i_dp_op_sel;
    logic [1:0]  i_dp_src1_sel, i_dp_src2_sel;
    logic [31:0] i_dp_rs1, i_dp_rs2, i_dp_pc, i_dp_imm, i_cdb_data;
    logic        i_dp_rs1_rdy, i_dp_rs2_rdy, i_cdb_vld, i_ex_accessable, i_flush;
    logic [5:0]  i_dp_rs1_tag, i_dp_rs2_tag, i_dp_rob_tag, i_cdb_tag;
    logic        o_is_vld;
    logic [3:0]  o_is_op_sel;
    logic [1:0]  o_is_src1_sel, o_is_src2_sel;
    logic [31:0] o_is_rs1, o_is_rs2, o_is_pc, o_is_imm;
    logic [5:0]  o_is_rob_tag;

    int   checks = 0;
    int   errors = 0;
    iss_t sbq[$];
    ent_t m[ENT];
    bit   mon_en = 0;
    bit   chk_rdy = 0;

    rs_alu dut (
        .clk(clk), .rst(rst), .o_dp_rdy(o_dp_rdy), .i_dp_vld(i_dp_vld),
        .i_dp_op_sel(i_dp_op_sel), .i_dp_src1_sel(i_dp_src1_sel),
        .i_dp_src2_sel(i_dp_src2_sel), .i_dp_rs1(i_dp_rs1), .i_dp_rs2(i_dp_rs2),
        .i_dp_rs1_rdy(i_dp_rs1_rdy), .i_dp_rs2_rdy(i_dp_rs2_rdy),
        .i_dp_rs1_tag(i_dp_rs1_tag), .i_dp_rs2_tag(i_dp_rs2_tag), .i_dp_pc(i_dp_pc),
        .i_dp_imm(i_dp_imm), .i_dp_rob_tag(i_dp_rob_tag), .i_cdb_vld(i_cdb_vld),
        .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data), .i_ex_accessable(i_ex_accessable),
        .o_is_vld(o_is_vld), .o_is_op_sel(o_is_op_sel), .o_is_src1_sel(o_is_src1_sel),
        .o_is_src2_sel(o_is_src2_sel), .o_is_rs1(o_is_rs1), .o_is_rs2(o_is_rs2),
        .o_is_pc(o_is_pc), .o_is_imm(o_is_imm), .o_is_rob_tag(o_is_rob_tag),
        .i_flush(i_flush)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: applies this cycle's inputs to the entry list, queues the expected issue.
    task automatic model_step(output bit exp_rdy);
        int sel = -1;
        int fr  = -1;
        exp_rdy = 0;
        for (int i = 0; i < ENT; i++) begin
            if (!m[i].vld && fr < 0) fr = i;
            if (m[i].vld && m[i].r1 && m[i].r2 && sel < 0) sel = i;
        end
        exp_rdy = (fr >= 0);
        if (sel >= 0 && i_ex_accessable && !i_flush && !rst) sbq.push_back(m[sel].pay);
        if (rst || i_flush) begin
            for (int i = 0; i < ENT; i++) m[i].vld = 0;
            return;
        end
        for (int i = 0; i < ENT; i++) begin
            if (m[i].vld && i_cdb_vld) begin
                if (!m[i].r1 && m[i].t1 == i_cdb_tag) begin m[i].r1 = 1; m[i].pay.rs1 = i_cdb_data; end
                if (!m[i].r2 && m[i].t2 == i_cdb_tag) begin m[i].r2 = 1; m[i].pay.rs2 = i_cdb_data; end
            end
        end
        if (sel >= 0 && i_ex_accessable) m[sel].vld = 0;
        if (i_dp_vld && fr >= 0) begin
            m[fr].vld = 1;
            m[fr].t1 = i_dp_rs1_tag;
            m[fr].t2 = i_dp_rs2_tag;
            m[fr].r1 = i_dp_rs1_rdy || (i_cdb_vld && i_cdb_tag == i_dp_rs1_tag);
            m[fr].r2 = i_dp_rs2_rdy || (i_cdb_vld && i_cdb_tag == i_dp_rs2_tag);
            m[fr].pay = '{op: i_dp_op_sel, s1: i_dp_src1_sel, s2: i_dp_src2_sel,
                          rs1: i_dp_rs1_rdy ? i_dp_rs1 : (m[fr].r1 ? i_cdb_data : i_dp_rs1),
                          rs2: i_dp_rs2_rdy ? i_dp_rs2 : (m[fr].r2 ? i_cdb_data : i_dp_rs2),
                          pc: i_dp_pc, imm: i_dp_imm, rob: i_dp_rob_tag};
        end
    endtask

    task automatic idle_inputs();
        rst = 0; i_dp_vld = 0; i_cdb_vld = 0; i_flush = 0;
    endtask

    // Inputs for this cycle are already set (posedge+1); run the model and advance.
    task automatic tick();
        bit er;
        model_step(er);
        #1;
        if (chk_rdy) chk("dp_rdy", o_dp_rdy, er);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic peek();
        #1;
    endtask

    task automatic dispatch(input logic [31:0] a, input bit ar, input logic [5:0] at,
                            input logic [31:0] b, input bit br, input logic [5:0] bt,
                            input logic [5:0] rob);
        i_dp_vld = 1;
        i_dp_rs1 = a; i_dp_rs1_rdy = ar; i_dp_rs1_tag = at;
        i_dp_rs2 = b; i_dp_rs2_rdy = br; i_dp_rs2_tag = bt;
        i_dp_rob_tag = rob;
        i_dp_op_sel = 4'($urandom); i_dp_src1_sel = 2'($urandom); i_dp_src2_sel = 2'($urandom);
        i_dp_pc = $urandom; i_dp_imm = $urandom;
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        i_cdb_vld = 1; i_cdb_tag = t; i_cdb_data = d;
    endtask

    // Scoreboard monitor: every presented issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_is_vld === 1'b1) begin
                iss_t act, exp;
                act = '{op: o_is_op_sel, s1: o_is_src1_sel, s2: o_is_src2_sel, rs1: o_is_rs1,
                        rs2: o_is_rs2, pc: o_is_pc, imm: o_is_imm, rob: o_is_rob_tag};
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue actual %h required none", act);
                end else begin
                    exp = sbq.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL issue_fields actual %h required %h", act, exp);
                    end
                end
            end else if (sbq.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_issue actual o_is_vld=%b required %h", o_is_vld, sbq[0]);
                sbq.delete();
            end
        end
    end

    initial begin
        foreach (m[i]) m[i] = '{vld: 0, r1: 0, r2: 0, t1: '0, t2: '0, pay: '0};
        i_dp_op_sel = 0; i_dp_src1_sel = 0; i_dp_src2_sel = 0; i_dp_rs1 = 0; i_dp_rs2 = 0;
        i_dp_rs1_rdy = 1; i_dp_rs2_rdy = 1; i_dp_rs1_tag = 0; i_dp_rs2_tag = 0;
        i_dp_pc = 0; i_dp_imm = 0; i_dp_rob_tag = 0; i_cdb_tag = 0; i_cdb_data = 0;
        i_ex_accessable = 0;
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 1; tick();
        rst = 1; tick();
        mon_en = 1; chk_rdy = 1;

        // Reset state
        peek(); chk("rst_dp_rdy", o_dp_rdy, 1); chk("rst_is_vld", o_is_vld, 0);
        tick();

        // Ready op issues one cycle after dispatch
        i_ex_accessable = 1;
        dispatch(5, 1, 0, 7, 1, 0, 3); tick();
        peek(); chk("d1_vld", o_is_vld, 1); chk("d1_rs1", o_is_rs1, 5);
        chk("d1_rs2", o_is_rs2, 7); chk("d1_rob", o_is_rob_tag, 3);
        tick();
        peek(); chk("d1_empty", o_is_vld, 0); tick();

        // Wakeup from CDB; non-matching tag does nothing
        dispatch(0, 0, 9, 2, 1, 0, 10); tick();
        cdb(8, 32'h5555); peek(); chk("d2_wait0", o_is_vld, 0); tick();
        cdb(9, 32'h1234); peek(); chk("d2_wait1", o_is_vld, 0); tick();
        peek(); chk("d2_vld", o_is_vld, 1); chk("d2_rs1", o_is_rs1, 32'h1234); tick();

        // Same-cycle dispatch bypass
        dispatch(1, 1, 0, 0, 0, 4, 11); cdb(4, 32'hAA); tick();
        peek(); chk("d3_vld", o_is_vld, 1); chk("d3_rs2", o_is_rs2, 32'hAA); tick();

        // Fill, drop 5th, drain in order
        i_ex_accessable = 0;
        for (int k = 0; k < 4; k++) begin dispatch(100 + k, 1, 0, 0, 1, 0, 6'(20 + k)); tick(); end
        peek(); chk("d4_full", o_dp_rdy, 0);
        dispatch(99, 1, 0, 0, 1, 0, 30); tick();
        peek(); chk("d4_still_full", o_dp_rdy, 0); chk("d4_no_issue", o_is_vld, 0);
        i_ex_accessable = 1;
        for (int k = 0; k < 4; k++) begin
            peek(); chk("d4_order_vld", o_is_vld, 1); chk("d4_order_rob", o_is_rob_tag, 20 + k);
            tick();
        end
        peek(); chk("d4_drained", o_is_vld, 0); chk("d4_rdy", o_dp_rdy, 1); tick();

        // Flush with two ready entries
        i_ex_accessable = 0;
        dispatch(1, 1, 0, 1, 1, 0, 40); tick();
        dispatch(2, 1, 0, 2, 1, 0, 41); tick();
        i_ex_accessable = 1; i_flush = 1;
        peek(); chk("d5_flush_vld", o_is_vld, 0); tick();
        peek(); chk("d5_after_vld", o_is_vld, 0); chk("d5_after_rdy", o_dp_rdy, 1); tick();

        // Reset with three valid entries and a pending issue
        i_ex_accessable = 0;
        for (int k = 0; k < 3; k++) begin dispatch(k, 1, 0, k, 1, 0, 6'(50 + k)); tick(); end
        i_ex_accessable = 1; rst = 1; tick();
        peek(); chk("d6_vld", o_is_vld, 0); chk("d6_rdy", o_dp_rdy, 1); tick();
        for (int k = 0; k < 3; k++) begin peek(); chk("d6_no_old", o_is_vld, 0); tick(); end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            i_ex_accessable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                dispatch($urandom, 1'($urandom), 6'($urandom_range(0, 7)), $urandom,
                         1'($urandom), 6'($urandom_range(0, 7)), 6'($urandom));
            if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 7)), $urandom);
            i_flush = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end

        // Drain: wake every tag so all remaining entries issue
        i_ex_accessable = 1;
        for (int n = 0; n < 32; n++) begin cdb(6'(n % 8), $urandom); tick(); end
        @(negedge clk); #1;
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
